sync_sram_be: RTL

Single-clock, parametrised simple-dual-port SRAM: one write port with per-byte enables, one read port with selectable read latency and read-during-write policy. A reset-driven clear sequencer zeroes the whole array and reports `Busy` while it runs. It is the single-clock successor to our dual-clock SRAM and serves as the storage primitive behind synchronous FIFOs and line buffers.

---
 rtl/sync_sram_be.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sync_sram_be.sv
// sync_sram_be
//   Single-clock simple-dual-port SRAM with per-byte write enables, a
//   selectable read latency (1 or 2 cycles) and read-during-write policy.
//   After every reset an optional clear sequencer zeroes the whole array and
//   holds Busy high. While Busy is high, all requests are ignored.
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   synchronous active-low reset
//   WRen    in   write request
//   WRaddr  in   write address (AddrLines bits)
//   WRdata  in   write data (Width bits)
//   WRbe    in   byte-lane enables, bit i covers WRdata[i*ByteW +: ByteW]
//   RDen    in   read request
//   RDaddr  in   read address (AddrLines bits)
//   RDdata  out  read data, holds its value between results
//   RDvalid out  one-cycle pulse marking a read result on RDdata
//   Busy    out  clear sweep in progress
module sync_sram_be #(
    parameter int Width        = 32,
    parameter int Depth        = 512,
    parameter int ByteW        = 8,
    parameter int RdLatency    = 1,
    parameter int RdMode       = 0,
    parameter int ClearOnReset = 1,
    localparam int AddrLines   = $clog2(Depth),
    localparam int NBE         = Width / ByteW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 WRen,
    input  logic [AddrLines-1:0] WRaddr,
    input  logic [Width-1:0]     WRdata,
    input  logic [NBE-1:0]       WRbe,
    input  logic                 RDen,
    input  logic [AddrLines-1:0] RDaddr,
    output logic [Width-1:0]     RDdata,
    output logic                 RDvalid,
    output logic                 Busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Depth held one bit wider than an address so non-power-of-two depths
    // compare cleanly against every representable address.
    localparam logic [AddrLines:0]   DEPTH_L   = (AddrLines + 1)'(Depth);
    localparam logic [AddrLines-1:0] LAST_ADDR = AddrLines'(Depth - 1);

    state_e               state_q;
    logic [AddrLines-1:0] cnt_q;
    logic [AddrLines-1:0] cnt_d;
    logic                 busy_q;
    logic [Width-1:0]     mem_q [Depth];

    logic                 ready_s;
    logic                 clr_we_s;
    logic                 wr_hit_s;
    logic                 rd_acc_s;
    logic [Width-1:0]     rd_old_s;
    logic [Width-1:0]     rd_word_s;
    logic [Width-1:0]     rd_data_q;
    logic                 rd_valid_q;

    // Lane-wise merge: enabled lanes take the new data, others keep old data.
    function automatic logic [Width-1:0] merge_bytes(
        input logic [Width-1:0] old_w,
        input logic [Width-1:0] new_w,
        input logic [NBE-1:0]   be
    );
        logic [Width-1:0] res;
        res = old_w;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                res[i*ByteW +: ByteW] = new_w[i*ByteW +: ByteW];
            end else begin
                res[i*ByteW +: ByteW] = old_w[i*ByteW +: ByteW];
            end
        end
        return res;
    endfunction

    function automatic logic in_range(input logic [AddrLines-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Request qualification and read-word selection (incl. collision policy).
    always_comb begin
        ready_s   = (state_q == ST_READY);
        clr_we_s  = rst_n && (state_q == ST_CLEAR);
        wr_hit_s  = rst_n && ready_s && WRen && in_range(WRaddr);
        rd_acc_s  = rst_n && ready_s && RDen;
        cnt_d     = cnt_q + 1'b1;
        if (in_range(RDaddr)) begin
            rd_old_s = mem_q[RDaddr];
        end else begin
            rd_old_s = '0;
        end
        // Write-first only differs from read-first on a same-address hit.
        if ((RdMode == 1) && wr_hit_s && (WRaddr == RDaddr)) begin
            rd_word_s = merge_bytes(rd_old_s, WRdata, WRbe);
        end else begin
            rd_word_s = rd_old_s;
        end
    end

    // Array write port, shared by the clear sweep and normal writes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_hit_s) begin
            mem_q[WRaddr] <= merge_bytes(mem_q[WRaddr], WRdata, WRbe);
        end
    end

    // Clear sequencer: sweeps every address once after reset, then stays READY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (ClearOnReset != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            busy_q  <= (ClearOnReset != 0);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                ST_READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    if (RdLatency == 2) begin : g_lat2
        logic [Width-1:0] s1_data_q;
        logic             s1_valid_q;

        // Two-stage read pipe: array sample, then output register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                s1_data_q  <= rd_word_s;
                s1_valid_q <= rd_acc_s;
                rd_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rd_data_q <= s1_data_q;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read: output register loaded on the accepting edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc_s;
                if (rd_acc_s) begin
                    rd_data_q <= rd_word_s;
                end
            end
        end
    end

    assign RDdata  = rd_data_q;
    assign RDvalid = rd_valid_q;
    assign Busy    = busy_q;

endmodule
